// File: rtl/wb_csr_bank_pkg.sv
// wb_csr_bank_pkg: shared definitions for the wb_csr_bank register bank.
//   state_t      - bus transaction FSM states
//   RO_OFS, IRQ_STAT_OFS, IRQ_EN_OFS - region offsets from BASE_ADDR
//   DATA_W       - bus data width
//   byte_merge() - replace the byte lanes of old_val selected by sel with wr_val
package wb_csr_bank_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam logic [31:0] RO_OFS       = 32'h0000_0100;
    localparam logic [31:0] IRQ_STAT_OFS = 32'h0000_0200;
    localparam logic [31:0] IRQ_EN_OFS   = 32'h0000_0204;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MEM_WAIT,
        ACK
    } state_t;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] wr_val,
        input logic [3:0]        sel
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int unsigned k = 0; k < 4; k++) begin
            if (sel[k]) res[8*k +: 8] = wr_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_csr_bank_irq.sv
// wb_csr_irq: sticky interrupt status with enable mask and registered request.
//   clk, rst_n  - clock, synchronous active-low reset
//   src         - level interrupt sources, sampled every cycle
//   clr         - per-bit clear strobe (W1C); a simultaneous set wins
//   en_we       - enable register write strobe
//   en_data     - enable write data, en_sel its byte selects
//   status      - sticky status bits
//   enable      - enable mask
//   irq         - |(status & enable), one cycle behind the registers
module wb_csr_irq
    import wb_csr_bank_pkg::*;
#(
    parameter int unsigned N_IRQ = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IRQ-1:0]  src,
    input  logic [N_IRQ-1:0]  clr,
    input  logic              en_we,
    input  logic [DATA_W-1:0] en_data,
    input  logic [3:0]        en_sel,
    output logic [N_IRQ-1:0]  status,
    output logic [N_IRQ-1:0]  enable,
    output logic              irq
);

    logic [DATA_W-1:0] en_full;
    logic [DATA_W-1:0] en_next;
    logic              unused_bits;

    always_comb begin
        en_full              = '0;
        en_full[N_IRQ-1:0]   = enable;
        en_next              = byte_merge(en_full, en_data, en_sel);
    end

    assign unused_bits = ^en_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status <= '0;
            enable <= '0;
            irq    <= 1'b0;
        end else begin
            status <= (status & ~clr) | src;
            if (en_we) enable <= en_next[N_IRQ-1:0];
            irq    <= |(status & enable);
        end
    end

endmodule

// File: rtl/wb_csr_bank.sv
// wb_csr_bank: Wishbone B4 classic CSR bank with RW/RO registers, W1C
// interrupt status/enable and a read window onto an external memory.
//   wb_clk_i, wb_rst_ni        - clock, synchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i/dat_i/adr_i - Wishbone slave request
//   wbs_ack_o, wbs_dat_o       - one-cycle acknowledge, registered read data
//   rw_q                       - flattened RW register contents
//   ro_i                       - flattened read-only status inputs
//   irq_src_i, irq_o           - interrupt sources, registered request
//   mem_rd_o, mem_adr_o, mem_dat_i - memory window read port
//   wbs_err_o                  - error pulse, only when WB_ERR_EN is defined
// Macro WB_ERR_EN: unmapped accesses and writes to RO/memory regions pulse
// wbs_err_o instead of wbs_ack_o and leave all state untouched.
module wb_csr_bank
    import wb_csr_bank_pkg::*;
#(
    parameter logic [31:0]        BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0]        MEM_BASE  = 32'h4000_0000,
    parameter int unsigned        N_RW      = 8,
    parameter int unsigned        N_RO      = 16,
    parameter int unsigned        N_IRQ     = 8,
    parameter int unsigned        MEM_AW    = 12,
    parameter int unsigned        MEM_LAT   = 1,
    parameter logic [32*N_RW-1:0] RW_RESET  = '0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [32*N_RW-1:0]  rw_q,
    input  logic [32*N_RO-1:0]  ro_i,
    input  logic [N_IRQ-1:0]    irq_src_i,
    output logic                irq_o,
    output logic                mem_rd_o,
    output logic [MEM_AW-3:0]   mem_adr_o,
    input  logic [31:0]         mem_dat_i
`ifdef WB_ERR_EN
    ,
    output logic                wbs_err_o
`endif
);

    state_t        state;
    logic [31:2]   adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic [2:0]    lat_cnt;
    logic [31:0]   rw_regs [N_RW];

    logic [31:0]   wofs;
    logic [31:0]   ro_wofs;
    logic          hit_rw, hit_ro, hit_stat, hit_en, hit_mem;
    logic [31:0]   rd_rw, rd_ro, rd_data;
    logic [31:0]   status_full, enable_full, clr_full;
    logic [N_IRQ-1:0] irq_status, irq_enable, irq_clr;
    logic          wr_commit;
    logic          unused_bits;

    // Word offset from BASE_ADDR; addresses below the base wrap to large
    // values and so miss every register range.
    assign wofs     = {2'b00, adr_q} - {2'b00, BASE_ADDR[31:2]};
    assign ro_wofs  = wofs - {2'b00, RO_OFS[31:2]};
    assign hit_rw   = wofs < N_RW;
    assign hit_ro   = (wofs >= {2'b00, RO_OFS[31:2]}) && (ro_wofs < N_RO);
    assign hit_stat = wofs == {2'b00, IRQ_STAT_OFS[31:2]};
    assign hit_en   = wofs == {2'b00, IRQ_EN_OFS[31:2]};
    assign hit_mem  = adr_q[31:MEM_AW] == MEM_BASE[31:MEM_AW];

`ifdef WB_ERR_EN
    logic bad;
    assign bad       = !(hit_rw || hit_ro || hit_stat || hit_en || hit_mem)
                     || (we_q && (hit_ro || hit_mem));
    assign wr_commit = (state == ACCESS) && we_q && !bad;
`else
    assign wr_commit = (state == ACCESS) && we_q;
`endif

    always_comb begin
        rd_rw = '0;
        for (int unsigned i = 0; i < N_RW; i++) begin
            if (wofs == i) rd_rw = rw_regs[i];
        end
        rd_ro = '0;
        for (int unsigned j = 0; j < N_RO; j++) begin
            if (ro_wofs == j) rd_ro = ro_i[32*j +: 32];
        end
        status_full              = '0;
        status_full[N_IRQ-1:0]   = irq_status;
        enable_full              = '0;
        enable_full[N_IRQ-1:0]   = irq_enable;
        if (hit_rw)        rd_data = rd_rw;
        else if (hit_ro)   rd_data = rd_ro;
        else if (hit_stat) rd_data = status_full;
        else if (hit_en)   rd_data = enable_full;
        else               rd_data = '0;
    end

    always_comb begin
        rw_q = '0;
        for (int unsigned i = 0; i < N_RW; i++) begin
            rw_q[32*i +: 32] = rw_regs[i];
        end
    end

    // W1C mask: written ones in the selected lanes.
    assign clr_full = byte_merge('0, dat_q, sel_q);
    assign irq_clr  = (wr_commit && hit_stat) ? clr_full[N_IRQ-1:0] : '0;

    assign unused_bits = ^{wbs_adr_i[1:0], clr_full};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            for (int unsigned i = 0; i < N_RW; i++) begin
                rw_regs[i] <= RW_RESET[32*i +: 32];
            end
        end else if (wr_commit && hit_rw) begin
            for (int unsigned i = 0; i < N_RW; i++) begin
                if (wofs == i) rw_regs[i] <= byte_merge(rw_regs[i], dat_q, sel_q);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            lat_cnt   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            mem_rd_o  <= 1'b0;
            mem_adr_o <= '0;
`ifdef WB_ERR_EN
            wbs_err_o <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= 1'b0;
            mem_rd_o  <= 1'b0;
`ifdef WB_ERR_EN
            wbs_err_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (wbs_stb_i && wbs_cyc_i && !wbs_ack_o) begin
                        adr_q <= wbs_adr_i[31:2];
                        dat_q <= wbs_dat_i;
                        sel_q <= wbs_sel_i;
                        we_q  <= wbs_we_i;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q && hit_mem) begin
                        mem_rd_o  <= 1'b1;
                        mem_adr_o <= adr_q[MEM_AW-1:2];
                        lat_cnt   <= '0;
                        state     <= MEM_WAIT;
                    end else begin
`ifdef WB_ERR_EN
                        if (bad) begin
                            wbs_err_o <= 1'b1;
                        end else
`endif
                        begin
                            wbs_ack_o <= 1'b1;
                            if (!we_q) wbs_dat_o <= rd_data;
                        end
                        state <= ACK;
                    end
                end
                MEM_WAIT: begin
                    if (lat_cnt == 3'(MEM_LAT)) begin
                        wbs_dat_o <= mem_dat_i;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    wb_csr_irq #(
        .N_IRQ (N_IRQ)
    ) u_irq (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .src     (irq_src_i),
        .clr     (irq_clr),
        .en_we   (wr_commit && hit_en),
        .en_data (dat_q),
        .en_sel  (sel_q),
        .status  (irq_status),
        .enable  (irq_enable),
        .irq     (irq_o)
    );

endmodule
